// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and constants for the UART transmitter.
//
// Contents:
//   CLKS_PER_BIT_DEFAULT : default clock cycles per serial bit (50 MHz / 115200 baud)
//   DATA_W               : width of one transmitted character
//   tx_state_e           : transmitter FSM state encoding
//
// Build option: UART_TX_PARITY_EN adds the PARITY state between DATA and STOP.

package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;
    localparam int DATA_W               = 8;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;
`endif

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if -- byte handshake between an upstream driver and uart_tx.
//
// Signals:
//   TxData  : byte offered by the upstream driver
//   XMitGo  : upstream has valid TxData
//   TxEmpty : holding register empty; TxData will be accepted
//
// Handshake: a byte transfers on every rising clock edge where
// XMitGo && TxEmpty. While TxEmpty is low, XMitGo is ignored and TxData
// is not sampled, so the driver may hold or change both freely.
//
// Modports:
//   master : upstream driver
//   slave  : uart_tx

interface uart_tx_if;
    import uart_pkg::*;

    logic [DATA_W-1:0] TxData;
    logic              XMitGo;
    logic              TxEmpty;

    modport master (output TxData, output XMitGo, input TxEmpty);
    modport slave  (input TxData, input XMitGo, output TxEmpty);

endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen -- per-bit cycle counter for the UART transmitter.
//
// Ports:
//   clock    : system clock, rising edge
//   reset    : synchronous, active-high
//   restart  : force the counter back to 0 on the next edge
//   bit_done : high during the last cycle (count == CLKS_PER_BIT-1) of a bit
//
// The counter returns to 0 after its last count, so it never runs past
// CLKS_PER_BIT-1.

module uart_baud_gen #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || restart || bit_done) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign bit_done = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- 8N1 UART transmitter with a one-byte holding register.
//
// Ports:
//   clock     : system clock, all logic on rising edge
//   reset     : synchronous, active-high; aborts any frame in progress
//   tx_bus    : uart_tx_if.slave (TxData, XMitGo in; TxEmpty out)
//   TxD       : registered serial output, idle high
//   TxBusy    : shifter is mid-frame (state != IDLE)
//   dbg_state : current FSM state, for observation only
//
// Frame: start bit (0), 8 data bits LSB first, stop bit (1), each
// CLKS_PER_BIT cycles. A byte waiting in the holding register at the last
// stop-bit cycle starts immediately, giving gapless back-to-back frames.
//
// Build option: UART_TX_PARITY_EN inserts an even-parity bit after bit 7.

module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    uart_tx_if.slave   tx_bus,
    output logic       TxD,
    output logic       TxBusy,
    output tx_state_e  dbg_state
);

    tx_state_e         state, state_n;
    logic [DATA_W-1:0] hold_q, hold_n;
    logic              hold_full, hold_full_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic              txd_n;
    logic              restart;
    logic              bit_done;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock    (clock),
        .reset    (reset),
        .restart  (restart),
        .bit_done (bit_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            hold_q    <= '0;
            hold_full <= 1'b0;
            shift_q   <= '0;
            bit_idx   <= '0;
            TxD       <= 1'b1;
        end else begin
            state     <= state_n;
            hold_q    <= hold_n;
            hold_full <= hold_full_n;
            shift_q   <= shift_n;
            bit_idx   <= bit_idx_n;
            TxD       <= txd_n;
        end
    end

    // Next-state logic. TxD is computed for the state being entered so the
    // registered output lines up with the state register.
    always_comb begin
        state_n     = state;
        hold_n      = hold_q;
        hold_full_n = hold_full;
        shift_n     = shift_q;
        bit_idx_n   = bit_idx;
        txd_n       = TxD;

        // Load only when empty; the transfers below only happen when full,
        // so a load and a transfer can never fall on the same edge.
        if (!hold_full && tx_bus.XMitGo) begin
            hold_n      = tx_bus.TxData;
            hold_full_n = 1'b1;
        end

        case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (hold_full) begin
                    shift_n     = hold_q;
                    hold_full_n = 1'b0;
                    state_n     = START;
                    txd_n       = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_n   = DATA;
                    bit_idx_n = 3'd0;
                    txd_n     = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        txd_n   = ^shift_q;
`else
                        state_n = STOP;
                        txd_n   = 1'b1;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        txd_n     = shift_q[bit_idx + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_n = STOP;
                    txd_n   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (hold_full) begin
                        shift_n     = hold_q;
                        hold_full_n = 1'b0;
                        state_n     = START;
                        txd_n       = 1'b0;
                    end else begin
                        state_n = IDLE;
                        txd_n   = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
            end
        endcase

        // Every state entry starts a fresh bit period; the counter is held at
        // 0 while idle so the START bit gets its full length.
        restart = (state_n != state) || (state == IDLE);
    end

    assign tx_bus.TxEmpty = !hold_full;
    assign TxBusy         = (state != IDLE);
    assign dbg_state      = state;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- self-checking bench for uart_tx with CLKS_PER_BIT = 4.
//
// The reference model works on edge times: a byte loaded at edge L starts
// its frame at max(L+1, end of the current frame); the line then carries
// frame bit k during edges [T + k*CLKS, T + (k+1)*CLKS). Build with
// UART_TX_PARITY_EN defined to exercise the parity frame.

module tb_uart_tx;
    import uart_pkg::*;

    localparam int CLKS = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * CLKS;

    typedef struct {
        logic       xmit;
        logic [7:0] data;
        logic       exp_txd;
        logic       exp_empty;
        logic       exp_busy;
    } vec_t;

    logic      clock = 1'b0;
    logic      reset;
    logic      TxD;
    logic      TxBusy;
    tx_state_e dbg_state;

    uart_tx_if bus ();

    uart_tx #(
        .CLKS_PER_BIT(CLKS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .tx_bus    (bus),
        .TxD       (TxD),
        .TxBusy    (TxBusy),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    int         edge_n    = 0;
    bit         m_pending = 1'b0;
    int         m_t       = 0;
    int         m_free    = 0;
    int         m_cur_t   = 0;
    logic [7:0] m_cur     = 8'h00;
    int         m_loads   = 0;

    vec_t vecs[64];
    int   nvec;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        logic [7:0] tmp;
        if (k == 0) return 1'b0;
        if (k <= 8) begin
            tmp = b >> (k - 1);
            return tmp[0];
        end
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", name, edge_n, act, exp);
        end
    endtask

    // Drive inputs, take one clock edge, advance the model, sample at +1.
    task automatic step(input logic r, input logic x, input logic [7:0] d);
        bit empty_before;
        reset      = r;
        bus.XMitGo = x;
        bus.TxData = d;
        @(posedge clock);
        edge_n++;
        if (r) begin
            m_pending = 1'b0;
            m_free    = edge_n;
            exp_q.delete();
        end else begin
            empty_before = !m_pending;
            if (m_pending && edge_n == m_t) begin
                m_pending = 1'b0;
                m_cur     = exp_q.pop_front();
                m_cur_t   = edge_n;
                m_free    = edge_n + FRAME;
            end
            if (x && empty_before) begin
                m_pending = 1'b1;
                m_t       = (edge_n + 1 > m_free) ? edge_n + 1 : m_free;
                exp_q.push_back(d);
                m_loads++;
            end
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        logic busy_e;
        logic txd_e;
        busy_e = (edge_n < m_free);
        txd_e  = busy_e ? frame_bit(m_cur, (edge_n - m_cur_t) / CLKS) : 1'b1;
        check({tag, "_txd"},   8'(TxD),         8'(txd_e));
        check({tag, "_empty"}, 8'(bus.TxEmpty), 8'(!m_pending));
        check({tag, "_busy"},  8'(TxBusy),      8'(busy_e));
    endtask

    task automatic run_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
            check_model(tag);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    // Send one byte and compare the parity bit window with a fixed value.
    task automatic send_parity(input logic [7:0] b, input logic par, input string tag);
        step(1'b0, 1'b1, b);
        check_model(tag);
        for (int i = 0; i < FRAME + 2; i++) begin
            step(1'b0, 1'b0, 8'h00);
            check_model(tag);
            if (edge_n >= m_cur_t && (edge_n - m_cur_t) / CLKS == 9 && edge_n < m_free)
                check({tag, "_parity"}, 8'(TxD), 8'(par));
        end
    endtask
`endif

    initial begin
        int base;
        reset         = 1'b1;
        bus.XMitGo    = 1'b0;
        bus.TxData    = 8'h00;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'h00);
            check_model("reset");
        end

        // Idle after reset
        run_idle("idle", 20);

        // Single 0x48 frame, cycle by cycle from a fixed table
        vecs[0] = '{xmit: 1'b1, data: 8'h48, exp_txd: 1'b1, exp_empty: 1'b0, exp_busy: 1'b0};
        for (int i = 1; i <= FRAME; i++)
            vecs[i] = '{xmit: 1'b0, data: 8'hFF, exp_txd: frame_bit(8'h48, (i - 1) / CLKS),
                        exp_empty: 1'b1, exp_busy: 1'b1};
        for (int i = FRAME + 1; i < FRAME + 5; i++)
            vecs[i] = '{xmit: 1'b0, data: 8'h00, exp_txd: 1'b1, exp_empty: 1'b1, exp_busy: 1'b0};
        nvec = FRAME + 5;
        for (int i = 0; i < nvec; i++) begin
            step(1'b0, vecs[i].xmit, vecs[i].data);
            check("vec_txd",   8'(TxD),         8'(vecs[i].exp_txd));
            check("vec_empty", 8'(bus.TxEmpty), 8'(vecs[i].exp_empty));
            check("vec_busy",  8'(TxBusy),      8'(vecs[i].exp_busy));
        end

        // Back-to-back 0x45 then 0x4C with XMitGo held high
        base = m_loads;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            step(1'b0, (m_loads < base + 2), (m_loads == base) ? 8'h45 : 8'h4C);
            check_model("b2b");
        end
        run_idle("b2b_tail", FRAME);

        // XMitGo held high with changing data while the holding register is full
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
            check_model("hold");
        end
        run_idle("hold_tail", 2 * FRAME + 4);

        // Reset mid-DATA of 0x0A with another byte waiting
        step(1'b0, 1'b1, 8'h0A);
        check_model("rst_frame");
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 8'h00);
            check_model("rst_frame");
        end
        step(1'b0, 1'b1, 8'h99);
        check_model("rst_frame");
        step(1'b0, 1'b0, 8'h00);
        check_model("rst_frame");
        step(1'b1, 1'b0, 8'h00);
        check("rst_txd",   8'(TxD),         8'h01);
        check("rst_empty", 8'(bus.TxEmpty), 8'h01);
        check("rst_busy",  8'(TxBusy),      8'h00);
        run_idle("post_rst", 2 * FRAME);

`ifdef UART_TX_PARITY_EN
        send_parity(8'h07, 1'b1, "par07");
        send_parity(8'h03, 1'b0, "par03");
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0),
                 8'($urandom_range(0, 255)));
            check_model("rand");
        end
        run_idle("drain", 2 * FRAME + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
